// File: rtl/packet_field_splitter_if.sv
// Payload-side bundle of the field splitter: dibit input stream plus the
// address, pixel and audio byte outputs and the end-of-packet status pulses.
interface packet_field_splitter_if #(
  parameter int ADDR_W = 24
);
  logic              axiiv;
  logic [1:0]        axiid;
  logic              addr_axiov;
  logic [ADDR_W-1:0] addr;
  logic              pixel_axiov;
  logic [7:0]        pixel;
  logic              pixel_last;
  logic              audio_axiov;
  logic [7:0]        audio;
  logic              audio_last;
  logic              frame_done;
  logic              frame_err;

  // Upstream side: drives the dibit stream and consumes the split fields.
  modport master (
    output axiiv, axiid,
    input  addr_axiov, addr, pixel_axiov, pixel, pixel_last,
    input  audio_axiov, audio, audio_last, frame_done, frame_err
  );

  // Splitter side.
  modport slave (
    input  axiiv, axiid,
    output addr_axiov, addr, pixel_axiov, pixel, pixel_last,
    output audio_axiov, audio, audio_last, frame_done, frame_err
  );
endinterface

// File: rtl/packet_field_splitter.sv
// Splits a 2-bit LSB-first payload stream into address, pixel and audio bytes;
// byte pulses appear one cycle after dibit 3; no backpressure, one byte per 4 cycles.
module packet_field_splitter #(
  parameter int ADDR_BYTES  = 3,
  parameter int PIXEL_BYTES = 80,
  parameter int AUDIO_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  packet_field_splitter_if.slave bus
);

  localparam int ADDR_W  = 8 * ADDR_BYTES;
  localparam int MAX_AP  = (ADDR_BYTES > PIXEL_BYTES) ? ADDR_BYTES : PIXEL_BYTES;
  localparam int MAX_SEC = (MAX_AP > AUDIO_BYTES) ? MAX_AP : AUDIO_BYTES;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] PIXEL_LAST = CNT_W'(PIXEL_BYTES - 1);
  localparam logic [CNT_W-1:0] AUDIO_LAST = CNT_W'((AUDIO_BYTES > 0) ? AUDIO_BYTES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PIXEL,
    S_AUDIO,
    S_TAIL
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        dib_cnt_q, dib_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [5:0]        sr_q, sr_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pixel_q, pixel_d;
  logic [7:0]        audio_q, audio_d;
  logic              addr_vld_q, addr_vld_d;
  logic              pixel_vld_q, pixel_vld_d;
  logic              pixel_last_q, pixel_last_d;
  logic              audio_vld_q, audio_vld_d;
  logic              audio_last_q, audio_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // sr keeps only the three previously received dibits; the incoming dibit
  // becomes the MS pair of the assembled byte.
  logic [7:0] byte_val;
  logic       byte_end;

  assign byte_val = {bus.axiid, sr_q};
  assign byte_end = (dib_cnt_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    dib_cnt_d    = dib_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    sr_d         = sr_q;
    overrun_d    = overrun_q;
    addr_d       = addr_q;
    pixel_d      = pixel_q;
    audio_d      = audio_q;
    addr_vld_d   = 1'b0;
    pixel_vld_d  = 1'b0;
    pixel_last_d = 1'b0;
    audio_vld_d  = 1'b0;
    audio_last_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.axiiv) begin
        state_d    = S_ADDR;
        sr_d       = byte_val[7:2];
        dib_cnt_d  = 2'd1;
        byte_cnt_d = '0;
      end
    end else if (!bus.axiiv) begin
      // Only a packet resting exactly on a byte boundary in TAIL is good.
      if (state_q == S_TAIL && !overrun_q && dib_cnt_q == 2'd0) begin
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      state_d    = S_IDLE;
      dib_cnt_d  = 2'd0;
      byte_cnt_d = '0;
      sr_d       = '0;
      overrun_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          sr_d      = byte_val[7:2];
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (byte_end) begin
            for (int k = 0; k < ADDR_BYTES; k++) begin
              if (byte_cnt_q == CNT_W'(k)) begin
                addr_d[ADDR_W-1-8*k -: 8] = byte_val;
              end
            end
            if (byte_cnt_q == ADDR_LAST) begin
              addr_vld_d = 1'b1;
              state_d    = S_PIXEL;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
          end
        end

        S_PIXEL: begin
          sr_d      = byte_val[7:2];
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (byte_end) begin
            pixel_d     = byte_val;
            pixel_vld_d = 1'b1;
            if (byte_cnt_q == PIXEL_LAST) begin
              pixel_last_d = 1'b1;
              state_d      = (AUDIO_BYTES > 0) ? S_AUDIO : S_TAIL;
              byte_cnt_d   = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
          end
        end

        S_AUDIO: begin
          sr_d      = byte_val[7:2];
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (byte_end) begin
            audio_d     = byte_val;
            audio_vld_d = 1'b1;
            if (byte_cnt_q == AUDIO_LAST) begin
              audio_last_d = 1'b1;
              state_d      = S_TAIL;
              byte_cnt_d   = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
          end
        end

        S_TAIL: begin
          overrun_d = 1'b1;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dib_cnt_q    <= 2'd0;
      byte_cnt_q   <= '0;
      sr_q         <= '0;
      overrun_q    <= 1'b0;
      addr_q       <= '0;
      pixel_q      <= '0;
      audio_q      <= '0;
      addr_vld_q   <= 1'b0;
      pixel_vld_q  <= 1'b0;
      pixel_last_q <= 1'b0;
      audio_vld_q  <= 1'b0;
      audio_last_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dib_cnt_q    <= dib_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      sr_q         <= sr_d;
      overrun_q    <= overrun_d;
      addr_q       <= addr_d;
      pixel_q      <= pixel_d;
      audio_q      <= audio_d;
      addr_vld_q   <= addr_vld_d;
      pixel_vld_q  <= pixel_vld_d;
      pixel_last_q <= pixel_last_d;
      audio_vld_q  <= audio_vld_d;
      audio_last_q <= audio_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.addr_axiov  = addr_vld_q;
  assign bus.addr        = addr_q;
  assign bus.pixel_axiov = pixel_vld_q;
  assign bus.pixel       = pixel_q;
  assign bus.pixel_last  = pixel_last_q;
  assign bus.audio_axiov = audio_vld_q;
  assign bus.audio       = audio_q;
  assign bus.audio_last  = audio_last_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_packet_field_splitter.sv
// Bench for packet_field_splitter: default layout and a 1/4/0 layout, directed
// and random packets compared as timestamped event streams against a byte-level model.
module tb_packet_field_splitter;

  typedef struct packed {
    logic        dut;
    logic [2:0]  kind;   // 1 addr, 2 pixel, 3 audio, 4 done, 5 err, 6 stray last
    logic [23:0] val;
    logic        last;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [1:0] pkt[$];

  packet_field_splitter_if #(.ADDR_W(24)) bus_a ();
  packet_field_splitter_if #(.ADDR_W(8))  bus_b ();

  packet_field_splitter #(.ADDR_BYTES(3), .PIXEL_BYTES(80), .AUDIO_BYTES(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  packet_field_splitter #(.ADDR_BYTES(1), .PIXEL_BYTES(4), .AUDIO_BYTES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.addr_axiov)  obs_q.push_back('{1'b0, 3'd1, bus_a.addr, 1'b0, cyc});
    if (bus_a.pixel_axiov) obs_q.push_back('{1'b0, 3'd2, {16'd0, bus_a.pixel}, bus_a.pixel_last, cyc});
    if (bus_a.audio_axiov) obs_q.push_back('{1'b0, 3'd3, {16'd0, bus_a.audio}, bus_a.audio_last, cyc});
    if (bus_a.frame_done)  obs_q.push_back('{1'b0, 3'd4, 24'd0, 1'b0, cyc});
    if (bus_a.frame_err)   obs_q.push_back('{1'b0, 3'd5, 24'd0, 1'b0, cyc});
    if ((bus_a.pixel_last && !bus_a.pixel_axiov) || (bus_a.audio_last && !bus_a.audio_axiov))
      obs_q.push_back('{1'b0, 3'd6, 24'd0, 1'b1, cyc});
    if (bus_b.addr_axiov)  obs_q.push_back('{1'b1, 3'd1, {16'd0, bus_b.addr}, 1'b0, cyc});
    if (bus_b.pixel_axiov) obs_q.push_back('{1'b1, 3'd2, {16'd0, bus_b.pixel}, bus_b.pixel_last, cyc});
    if (bus_b.audio_axiov) obs_q.push_back('{1'b1, 3'd3, {16'd0, bus_b.audio}, bus_b.audio_last, cyc});
    if (bus_b.frame_done)  obs_q.push_back('{1'b1, 3'd4, 24'd0, 1'b0, cyc});
    if (bus_b.frame_err)   obs_q.push_back('{1'b1, 3'd5, 24'd0, 1'b0, cyc});
    if ((bus_b.pixel_last && !bus_b.pixel_axiov) || (bus_b.audio_last && !bus_b.audio_axiov))
      obs_q.push_back('{1'b1, 3'd6, 24'd0, 1'b1, cyc});
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic drive(input bit dut, input logic v, input logic [1:0] d);
    if (dut) begin
      bus_b.axiiv = v; bus_b.axiid = d;
    end else begin
      bus_a.axiiv = v; bus_a.axiid = d;
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) pkt.push_back(b[2*i +: 2]);
  endtask

  task automatic rand_pkt(input int n);
    pkt.delete();
    repeat (n) pkt.push_back(2'($urandom_range(0, 3)));
  endtask

  // Sends pkt; the first dibit is sampled at edge 'start', dibit k at start+k.
  task automatic send(input bit dut, input bit terminate, output int start);
    start = 0;
    foreach (pkt[k]) begin
      @(negedge clk);
      if (k == 0) start = cyc + 1;
      drive(dut, 1'b1, pkt[k]);
    end
    if (terminate) begin
      @(negedge clk);
      drive(dut, 1'b0, 2'd0);
    end
  endtask

  // Reference: cut the dibit list into whole bytes, assign each byte to its
  // section by index, and judge the packet by its total dibit count.
  task automatic model(input bit dut, input int na, input int np, input int nu,
                       input int start, input bit ended);
    int          nb;
    int          v;
    logic [23:0] acc;
    nb  = pkt.size() / 4;
    acc = '0;
    for (int j = 0; j < nb; j++) begin
      v = pkt[4*j] + 4 * pkt[4*j+1] + 16 * pkt[4*j+2] + 64 * pkt[4*j+3];
      if (j < na) begin
        acc = (acc << 8) | 24'(v);
        if (j == na - 1) exp_q.push_back('{dut, 3'd1, acc, 1'b0, 32'(start + 4*j + 3)});
      end else if (j < na + np) begin
        exp_q.push_back('{dut, 3'd2, 24'(v), (j == na + np - 1), 32'(start + 4*j + 3)});
      end else if (j < na + np + nu) begin
        exp_q.push_back('{dut, 3'd3, 24'(v), (j == na + np + nu - 1), 32'(start + 4*j + 3)});
      end
    end
    if (ended) begin
      if (pkt.size() == 4 * (na + np + nu))
        exp_q.push_back('{dut, 3'd4, 24'd0, 1'b0, 32'(start + pkt.size())});
      else
        exp_q.push_back('{dut, 3'd5, 24'd0, 1'b0, 32'(start + pkt.size())});
    end
  endtask

  task automatic flush_check(input string tag);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) check($sformatf("%s_ev%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_a(input string tag);
    int st;
    send(1'b0, 1'b1, st);
    model(1'b0, 3, 80, 16, st, 1'b1);
    flush_check(tag);
  endtask

  task automatic run_b(input string tag);
    int st;
    send(1'b1, 1'b1, st);
    model(1'b1, 1, 4, 0, st, 1'b1);
    flush_check(tag);
  endtask

  initial begin
    int st1;
    int st2;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    check("reset_a", 64'({bus_a.addr_axiov, bus_a.addr, bus_a.pixel_axiov, bus_a.pixel, bus_a.pixel_last,
                          bus_a.audio_axiov, bus_a.audio, bus_a.audio_last, bus_a.frame_done, bus_a.frame_err}), 64'd0);
    check("reset_b", 64'({bus_b.addr_axiov, bus_b.addr, bus_b.pixel_axiov, bus_b.pixel, bus_b.pixel_last,
                          bus_b.audio_axiov, bus_b.audio, bus_b.audio_last, bus_b.frame_done, bus_b.frame_err}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal packet: 0x123456, pixels 0..79, audio 0xA0..0xAF.
    pkt.delete();
    add_byte(8'h12); add_byte(8'h34); add_byte(8'h56);
    for (int i = 0; i < 80; i++) add_byte(8'(i));
    for (int i = 0; i < 16; i++) add_byte(8'(8'hA0 + i));
    run_a("nominal");

    // Short: ends right after pixel byte 40.
    pkt.delete();
    for (int i = 0; i < 44; i++) add_byte(8'($urandom_range(0, 255)));
    run_a("short");

    // Long: four dibits past the last audio byte.
    pkt.delete();
    for (int i = 0; i < 99; i++) add_byte(8'($urandom_range(0, 255)));
    repeat (4) pkt.push_back(2'($urandom_range(0, 3)));
    run_a("long");

    // Mid-byte: two dibits into audio byte 5.
    pkt.delete();
    for (int i = 0; i < 88; i++) add_byte(8'($urandom_range(0, 255)));
    repeat (2) pkt.push_back(2'($urandom_range(0, 3)));
    run_a("midbyte");

    for (int r = 0; r < 4; r++) begin
      rand_pkt(390 + $urandom_range(0, 12));
      run_a($sformatf("rand_a_near%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      rand_pkt($urandom_range(1, 30));
      run_a($sformatf("rand_a_tiny%0d", r));
    end

    // Compact layout: 1 address byte, 4 pixels, no audio.
    pkt.delete();
    add_byte(8'h5A); add_byte(8'hC1); add_byte(8'h02); add_byte(8'h3F); add_byte(8'hE4);
    run_b("b_nominal");
    for (int r = 0; r < 5; r++) begin
      rand_pkt($urandom_range(1, 28));
      run_b($sformatf("rand_b%0d", r));
    end

    // Asynchronous reset mid-pixel, between clock edges.
    pkt.delete();
    for (int i = 0; i < 13; i++) add_byte(8'($urandom_range(1, 255)));
    pkt.push_back(2'd1);
    send(1'b0, 1'b0, st1);
    model(1'b0, 3, 80, 16, st1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_zero", 64'({bus_a.addr_axiov, bus_a.addr, bus_a.pixel_axiov, bus_a.pixel, bus_a.pixel_last,
                                 bus_a.audio_axiov, bus_a.audio, bus_a.audio_last, bus_a.frame_done, bus_a.frame_err}), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    flush_check("rst_drop");

    // Two identical nominal packets separated by a single low cycle.
    pkt.delete();
    add_byte(8'hAB); add_byte(8'hCD); add_byte(8'hEF);
    for (int i = 0; i < 96; i++) add_byte(8'($urandom_range(0, 255)));
    send(1'b0, 1'b1, st1);
    send(1'b0, 1'b1, st2);
    check("b2b_gap", 64'(st2 - st1), 64'(pkt.size() + 1));
    model(1'b0, 3, 80, 16, st1, 1'b1);
    model(1'b0, 3, 80, 16, st2, 1'b1);
    flush_check("back2back");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
